// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: one-cycle slice with reset > flush > stall > load priority and WB write bypass.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              wb_regwrite_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [ADDR_W-1:0] rs1_addr_o,
    output logic [ADDR_W-1:0] rs2_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [CTRL_W-1:0] ctrl_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o
`endif
);

    // Pipeline control: flush_i turns the slot into a bubble on the next edge
    // regardless of stall_i; stall_i alone freezes the slot; otherwise ID is loaded.
    logic wb_live;
    logic byp_rs1, byp_rs2;
    logic ref_rs1, ref_rs2;

    always_comb begin
        wb_live = wb_regwrite_i && (wb_rd_i != '0);
        byp_rs1 = wb_live && (wb_rd_i == rs1_addr_i);
        byp_rs2 = wb_live && (wb_rd_i == rs2_addr_i);
        ref_rs1 = valid_o && wb_live && (wb_rd_i == rs1_addr_o);
        ref_rs2 = valid_o && wb_live && (wb_rd_i == rs2_addr_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_o    <= 1'b0;
            pc_o       <= '0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            imm_o      <= '0;
            rs1_addr_o <= '0;
            rs2_addr_o <= '0;
            rd_addr_o  <= '0;
            ctrl_o     <= '0;
        end else if (stall_i) begin
            // Held operands track WB writes so EX never consumes stale data.
            if (ref_rs1) rs1_data_o <= wb_data_i;
            if (ref_rs2) rs2_data_o <= wb_data_i;
        end else begin
            valid_o    <= valid_i;
            pc_o       <= pc_i;
            rs1_data_o <= byp_rs1 ? wb_data_i : rs1_data_i;
            rs2_data_o <= byp_rs2 ? wb_data_i : rs2_data_i;
            imm_o      <= imm_i;
            rs1_addr_o <= rs1_addr_i;
            rs2_addr_o <= rs2_addr_i;
            rd_addr_o  <= rd_addr_i;
            ctrl_o     <= valid_i ? ctrl_i : '0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_i && !flush_i && (stall_cnt_o != 32'hFFFF_FFFF))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if ((flush_i || (!stall_i && !valid_i)) && (bubble_cnt_o != 32'hFFFF_FFFF))
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table, randomized run against a reference model,
// and counter checks when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [7:0]  ctrl;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
        logic [7:0]  ctrl;
    } out_t;

    typedef struct {
        in_t         in;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ers1;
        logic [31:0] ers2;
        logic [4:0]  erd;
        logic [7:0]  ectrl;
    } vec_t;

    localparam int OUT_W = $bits(out_t);
    localparam int NVEC  = 17;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [7:0]  ctrl_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [7:0]  ctrl_o;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_o, bubble_cnt_o;
`endif

    int checks = 0;
    int failures = 0;
    logic [OUT_W-1:0] exp_q[$];
    out_t model;
    vec_t vecs[NVEC];

    id_ex_stage_reg dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .ctrl_i(ctrl_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .ctrl_o(ctrl_o)
`ifdef ID_EX_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    // Clock / reset block
    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o = '{valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o, ctrl_o};
        return o;
    endfunction

    function automatic logic wb_hits(in_t i, logic [4:0] a);
        return i.wbw && (i.wbrd != 5'd0) && (i.wbrd == a);
    endfunction

    // Reference model: what EX should see after one edge, stated as the pipeline rules.
    function automatic out_t model_next(out_t cur, in_t i);
        out_t n;
        n = cur;
        if (i.rst || i.flush) begin
            n = '0;
        end else if (i.stall) begin
            if (cur.valid && wb_hits(i, cur.rs1a)) n.rs1 = i.wbd;
            if (cur.valid && wb_hits(i, cur.rs2a)) n.rs2 = i.wbd;
        end else begin
            n.valid = i.valid;
            n.pc    = i.pc;
            n.rs1   = wb_hits(i, i.rs1a) ? i.wbd : i.rs1d;
            n.rs2   = wb_hits(i, i.rs2a) ? i.wbd : i.rs2d;
            n.imm   = i.imm;
            n.rs1a  = i.rs1a;
            n.rs2a  = i.rs2a;
            n.rda   = i.rda;
            n.ctrl  = i.valid ? i.ctrl : 8'h00;
        end
        return n;
    endfunction

    task automatic drive(input in_t v);
        rst_i = v.rst; flush_i = v.flush; stall_i = v.stall; valid_i = v.valid;
        pc_i = v.pc; rs1_data_i = v.rs1d; rs2_data_i = v.rs2d; imm_i = v.imm;
        rs1_addr_i = v.rs1a; rs2_addr_i = v.rs2a; rd_addr_i = v.rda; ctrl_i = v.ctrl;
        wb_regwrite_i = v.wbw; wb_rd_i = v.wbrd; wb_data_i = v.wbd;
    endtask

    // Drive one cycle, advance the model, then score the DUT 1 time unit after the edge.
    task automatic apply(input in_t v);
        out_t got, e;
        drive(v);
        model = model_next(model, v);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        got = dut_out();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, got, e);
        end
    endtask

    initial begin
        in_t v;
        out_t got;
        model = '0;
        drive('0);
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < NVEC; k++) begin
            vecs[k] = '{in: '0, ev: 1'b0, epc: 32'h0, ers1: 32'h0, ers2: 32'h0, erd: 5'd0, ectrl: 8'h00};
        end
        vecs[0].in.rst = 1'b1;
        vecs[1].in.rst = 1'b1; vecs[1].in.valid = 1'b1; vecs[1].in.pc = 32'hFFFF; vecs[1].in.ctrl = 8'hFF;
        vecs[2].in.valid = 1'b1; vecs[2].in.pc = 32'h10; vecs[2].in.rs1d = 32'h1234_5678;
        vecs[2].in.rda = 5'd5; vecs[2].in.ctrl = 8'h01;
        vecs[2].ev = 1'b1; vecs[2].epc = 32'h10; vecs[2].ers1 = 32'h1234_5678; vecs[2].erd = 5'd5; vecs[2].ectrl = 8'h01;
        vecs[3].in.valid = 1'b1; vecs[3].in.pc = 32'h1C; vecs[3].in.rs1d = 32'h1111;
        vecs[3].in.rda = 5'd6; vecs[3].in.ctrl = 8'h05;
        vecs[3].ev = 1'b1; vecs[3].epc = 32'h1C; vecs[3].ers1 = 32'h1111; vecs[3].erd = 5'd6; vecs[3].ectrl = 8'h05;
        for (int k = 4; k < 7; k++) begin
            vecs[k].in.stall = 1'b1; vecs[k].in.valid = 1'b1; vecs[k].in.pc = 32'h20 + 32'(4 * (k - 4));
            vecs[k].ev = 1'b1; vecs[k].epc = 32'h1C; vecs[k].ers1 = 32'h1111; vecs[k].erd = 5'd6; vecs[k].ectrl = 8'h05;
        end
        vecs[7].in.valid = 1'b1; vecs[7].in.pc = 32'h28; vecs[7].in.rda = 5'd2; vecs[7].in.ctrl = 8'h01;
        vecs[7].ev = 1'b1; vecs[7].epc = 32'h28; vecs[7].erd = 5'd2; vecs[7].ectrl = 8'h01;
        vecs[8].in.flush = 1'b1; vecs[8].in.stall = 1'b1; vecs[8].in.valid = 1'b1;
        vecs[8].in.pc = 32'h2C; vecs[8].in.rda = 5'd4; vecs[8].in.ctrl = 8'h07;
        vecs[9].in.valid = 1'b1; vecs[9].in.pc = 32'h30; vecs[9].in.rda = 5'd8; vecs[9].in.ctrl = 8'h01;
        vecs[9].in.rs1a = 5'd7; vecs[9].in.rs2a = 5'd7;
        vecs[9].in.wbw = 1'b1; vecs[9].in.wbrd = 5'd7; vecs[9].in.wbd = 32'hDEAD_BEEF;
        vecs[9].ev = 1'b1; vecs[9].epc = 32'h30; vecs[9].ers1 = 32'hDEAD_BEEF; vecs[9].ers2 = 32'hDEAD_BEEF;
        vecs[9].erd = 5'd8; vecs[9].ectrl = 8'h01;
        vecs[10].in.valid = 1'b1; vecs[10].in.pc = 32'h34; vecs[10].in.rs1d = 32'hAAAA_0000;
        vecs[10].in.rs2d = 32'hBBBB_0000; vecs[10].in.wbw = 1'b1; vecs[10].in.wbd = 32'hDEAD_BEEF;
        vecs[10].ev = 1'b1; vecs[10].epc = 32'h34; vecs[10].ers1 = 32'hAAAA_0000; vecs[10].ers2 = 32'hBBBB_0000;
        vecs[11].in.valid = 1'b1; vecs[11].in.pc = 32'h38; vecs[11].in.rs1a = 5'd2; vecs[11].in.rs2a = 5'd3;
        vecs[11].in.rs1d = 32'h11; vecs[11].in.rs2d = 32'h22; vecs[11].in.rda = 5'd9; vecs[11].in.ctrl = 8'h01;
        vecs[11].ev = 1'b1; vecs[11].epc = 32'h38; vecs[11].ers1 = 32'h11; vecs[11].ers2 = 32'h22;
        vecs[11].erd = 5'd9; vecs[11].ectrl = 8'h01;
        vecs[12].in.stall = 1'b1; vecs[12].in.wbw = 1'b1; vecs[12].in.wbrd = 5'd3; vecs[12].in.wbd = 32'hCAFE_0001;
        vecs[12].ev = 1'b1; vecs[12].epc = 32'h38; vecs[12].ers1 = 32'h11; vecs[12].ers2 = 32'hCAFE_0001;
        vecs[12].erd = 5'd9; vecs[12].ectrl = 8'h01;
        vecs[13].in.flush = 1'b1;
        vecs[14].in.pc = 32'h3C; vecs[14].in.rs1a = 5'd2; vecs[14].in.rs2a = 5'd3;
        vecs[14].in.rs1d = 32'h11; vecs[14].in.rs2d = 32'h22; vecs[14].in.ctrl = 8'hFF;
        vecs[14].epc = 32'h3C; vecs[14].ers1 = 32'h11; vecs[14].ers2 = 32'h22;
        vecs[15].in.stall = 1'b1; vecs[15].in.wbw = 1'b1; vecs[15].in.wbrd = 5'd3; vecs[15].in.wbd = 32'hCAFE_0001;
        vecs[15].epc = 32'h3C; vecs[15].ers1 = 32'h11; vecs[15].ers2 = 32'h22;
        vecs[16].in.rst = 1'b1; vecs[16].in.stall = 1'b1; vecs[16].in.valid = 1'b1; vecs[16].in.pc = 32'h40;

        for (int k = 0; k < NVEC; k++) begin
            apply(vecs[k].in);
            got = dut_out();
            checks++;
            if (got.valid !== vecs[k].ev || got.pc !== vecs[k].epc || got.rs1 !== vecs[k].ers1 ||
                got.rs2 !== vecs[k].ers2 || got.rda !== vecs[k].erd || got.ctrl !== vecs[k].ectrl) begin
                failures++;
                $display("FAIL vec%0d got v=%b pc=%h rs1=%h rs2=%h rd=%0d ctrl=%h exp v=%b pc=%h rs1=%h rs2=%h rd=%0d ctrl=%h",
                         k, got.valid, got.pc, got.rs1, got.rs2, got.rda, got.ctrl,
                         vecs[k].ev, vecs[k].epc, vecs[k].ers1, vecs[k].ers2, vecs[k].erd, vecs[k].ectrl);
            end
        end

        // Randomized traffic with a small register window so bypass and refresh fire often.
        for (int n = 0; n < 400; n++) begin
            v.rst   = ($urandom_range(0, 49) == 0);
            v.flush = ($urandom_range(0, 7) == 0);
            v.stall = ($urandom_range(0, 3) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.pc    = $urandom;
            v.rs1d  = $urandom;
            v.rs2d  = $urandom;
            v.imm   = $urandom;
            v.rs1a  = 5'($urandom_range(0, 3));
            v.rs2a  = 5'($urandom_range(0, 3));
            v.rda   = 5'($urandom_range(0, 31));
            v.ctrl  = 8'($urandom);
            v.wbw   = ($urandom_range(0, 1) == 1);
            v.wbrd  = 5'($urandom_range(0, 3));
            v.wbd   = $urandom;
            apply(v);
        end

`ifdef ID_EX_PERF_CNT_EN
        v = '0; v.rst = 1'b1;
        apply(v);
        v = '0; v.stall = 1'b1; v.valid = 1'b1;
        repeat (4) apply(v);
        v = '0; v.flush = 1'b1;
        repeat (2) apply(v);
        v = '0;
        apply(v);
        checks++;
        if (stall_cnt_o !== 32'd4 || bubble_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL perf_counts got stall=%0d bubble=%0d exp stall=4 bubble=3", stall_cnt_o, bubble_cnt_o);
        end
        force dut.stall_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_o;
        v = '0; v.stall = 1'b1;
        apply(v);
        checks++;
        if (stall_cnt_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL stall_sat got=%h exp=ffffffff", stall_cnt_o);
        end
`endif

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
